// File: rtl/result_tx.sv
// Serialises a {max730, max850} pair to the microcontroller as one framed
// transfer: cs_n low, 2*DATLEN bits MSB first on a divided sclk, then done.
//
// state | meaning
// IDLE  | ready for a load, cs_n high, sclk low
// SETUP | cs_n low, first bit on sdo, sclk low for CLK_DIV cycles
// SHIFT | per bit: sclk high CLK_DIV cycles, then low CLK_DIV cycles
// HOLD  | cs_n still low, sclk low for CLK_DIV cycles before release
module result_tx #(
   parameter int DATLEN  = 12,
   parameter int CLK_DIV = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATLEN-1:0] max730,
   input  logic [DATLEN-1:0] max850,
   input  logic              load,
   output logic              ready,
   output logic              cs_n,
   output logic              sclk,
   output logic              sdo,
   output logic              done,
   output logic              lost
);

   localparam int FW   = 2 * DATLEN;
   localparam int DIVW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int BITW = $clog2(FW);
   localparam logic [DIVW-1:0] DIV_LAST = DIVW'(CLK_DIV - 1);
   localparam logic [BITW-1:0] BIT_LAST = BITW'(FW - 1);

   typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;

   state_t          state_q;
   logic [DIVW-1:0] div_q;
   logic [BITW-1:0] bit_q;
   logic [FW-1:0]   shreg_q;
   logic            ready_q;
   logic            cs_n_q;
   logic            sclk_q;
   logic            sdo_q;
   logic            done_q;
   logic            lost_q;

   logic accept;
   logic div_end;

   assign accept  = load & ready_q;
   assign div_end = (div_q == '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         div_q   <= '0;
         bit_q   <= '0;
         shreg_q <= '0;
         ready_q <= 1'b1;
         cs_n_q  <= 1'b1;
         sclk_q  <= 1'b0;
         sdo_q   <= 1'b0;
         done_q  <= 1'b0;
         lost_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (load && !ready_q) begin
            lost_q <= 1'b1;
         end
         case (state_q)
            IDLE: begin
               if (accept) begin
                  shreg_q <= {max730, max850};
                  sdo_q   <= max730[DATLEN-1];
                  ready_q <= 1'b0;
                  cs_n_q  <= 1'b0;
                  sclk_q  <= 1'b0;
                  div_q   <= DIV_LAST;
                  state_q <= SETUP;
               end
            end
            SETUP: begin
               if (div_end) begin
                  sclk_q  <= 1'b1;
                  div_q   <= DIV_LAST;
                  bit_q   <= BIT_LAST;
                  state_q <= SHIFT;
               end else begin
                  div_q <= div_q - 1'b1;
               end
            end
            SHIFT: begin
               if (!div_end) begin
                  div_q <= div_q - 1'b1;
               end else begin
                  div_q <= DIV_LAST;
                  // sdo only moves on the falling sclk edge, so it is stable across the rising edge
                  if (sclk_q) begin
                     sclk_q  <= 1'b0;
                     shreg_q <= {shreg_q[FW-2:0], 1'b0};
                     sdo_q   <= shreg_q[FW-2];
                  end else if (bit_q == '0) begin
                     state_q <= HOLD;
                  end else begin
                     bit_q  <= bit_q - 1'b1;
                     sclk_q <= 1'b1;
                  end
               end
            end
            HOLD: begin
               if (div_end) begin
                  cs_n_q  <= 1'b1;
                  done_q  <= 1'b1;
                  ready_q <= 1'b1;
                  sdo_q   <= 1'b0;
                  shreg_q <= '0;
                  state_q <= IDLE;
               end else begin
                  div_q <= div_q - 1'b1;
               end
            end
            default: begin
               state_q <= IDLE;
               ready_q <= 1'b1;
               cs_n_q  <= 1'b1;
               sclk_q  <= 1'b0;
               sdo_q   <= 1'b0;
            end
         endcase
      end
   end

   assign ready = ready_q;
   assign cs_n  = cs_n_q;
   assign sclk  = sclk_q;
   assign sdo   = sdo_q;
   assign done  = done_q;
   assign lost  = lost_q;

endmodule
